item_placer: RTL

//  Responder side of the reward-item set_require/set_finish handshake. Accepts a requested

---
 rtl/item_placer.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/item_placer.sv
// Reward-item placer: accepts a generator request, probes the map for a free tile,
// publishes the placed item and issues a one-clk reward pulse on tank pickup.
// Latency: request to set_finish takes 2*N+1 clks for N map probes. Backpressure:
// the generator holds set_require until set_finish is seen, and new requests wait until IDLE.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   tick_4hz               4 Hz strobe that ages a placed item
//   set_require, item_*    request from the generator (type 0 = not yet valid)
//   set_finish             request resolved (placed or rejected), cleared after set_require drops
//   map_qry_x/y            map probe address; map_blocked returns 1 clk later
//   tank_xpos/ypos         player tank tile, compared against the placed item
//   item_valid, item_disp_* placed item for the renderer (all zero when no item)
//   reward_pulse/type      one-clk pickup strobe with the collected type
module item_placer #(
    parameter int X_MIN     = 4,
    parameter int X_MAX     = 19,
    parameter int MAX_TRIES = 4,
    parameter int LIFETIME  = 40
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_4hz,
    input  logic       set_require,
    input  logic [2:0] item_type,
    input  logic [4:0] item_xpos,
    input  logic [4:0] item_ypos,
    output logic       set_finish,
    output logic [4:0] map_qry_x,
    output logic [4:0] map_qry_y,
    input  logic       map_blocked,
    input  logic [4:0] tank_xpos,
    input  logic [4:0] tank_ypos,
    output logic       item_valid,
    output logic [2:0] item_disp_type,
    output logic [4:0] item_disp_x,
    output logic [4:0] item_disp_y,
    output logic       reward_pulse,
    output logic [2:0] reward_type
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_QUERY  = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_ACTIVE = 2'd3;

    localparam logic [4:0] XMIN5     = 5'(X_MIN);
    localparam logic [4:0] XMAX5     = 5'(X_MAX);
    localparam logic [3:0] TRIES_LIM = 4'(MAX_TRIES);
    localparam logic [7:0] LIFE_LAST = 8'(LIFETIME - 1);

    logic [1:0] state_q, state_d;
    logic [2:0] type_q, type_d;
    logic [3:0] tries_q, tries_d;
    logic [7:0] life_q, life_d;
    // The probe address registers double as the current candidate tile, so the
    // address is already on the map port during QUERY and the answer lands in WAIT.
    logic [4:0] qry_x_q, qry_x_d;
    logic [4:0] qry_y_q, qry_y_d;
    logic       finish_q, finish_d;
    logic       valid_q, valid_d;
    logic [2:0] disp_type_q, disp_type_d;
    logic [4:0] disp_x_q, disp_x_d;
    logic [4:0] disp_y_q, disp_y_d;
    logic       pulse_q, pulse_d;
    logic [2:0] rtype_q, rtype_d;

    logic [4:0] next_x;
    logic       pickup;

    assign next_x = (qry_x_q == XMAX5) ? XMIN5 : qry_x_q + 5'd1;
    assign pickup = (tank_xpos == disp_x_q) && (tank_ypos == disp_y_q);

    always_comb begin
        state_d     = state_q;
        type_d      = type_q;
        tries_d     = tries_q;
        life_d      = life_q;
        qry_x_d     = qry_x_q;
        qry_y_d     = qry_y_q;
        // set_finish falls one clk after the generator lets go, whatever the state.
        finish_d    = set_require ? finish_q : 1'b0;
        valid_d     = valid_q;
        disp_type_d = disp_type_q;
        disp_x_d    = disp_x_q;
        disp_y_d    = disp_y_q;
        pulse_d     = 1'b0;
        rtype_d     = 3'd0;

        case (state_q)
            S_IDLE: begin
                if (set_require && (item_type != 3'd0) && !finish_q) begin
                    type_d  = item_type;
                    qry_x_d = item_xpos;
                    qry_y_d = item_ypos;
                    tries_d = 4'd0;
                    state_d = S_QUERY;
                end
            end
            S_QUERY: begin
                state_d = set_require ? S_WAIT : S_IDLE;
            end
            S_WAIT: begin
                if (!set_require) begin
                    // Generator timed out: drop the request silently.
                    state_d = S_IDLE;
                end else if (!map_blocked) begin
                    finish_d    = 1'b1;
                    valid_d     = 1'b1;
                    disp_type_d = type_q;
                    disp_x_d    = qry_x_q;
                    disp_y_d    = qry_y_q;
                    life_d      = 8'd0;
                    state_d     = S_ACTIVE;
                end else if ((tries_q + 4'd1) < TRIES_LIM) begin
                    qry_x_d = next_x;
                    tries_d = tries_q + 4'd1;
                    state_d = S_QUERY;
                end else begin
                    finish_d = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            S_ACTIVE: begin
                // Pickup is checked before expiry so a same-clk pickup still pays out.
                if (pickup) begin
                    pulse_d = 1'b1;
                    rtype_d = disp_type_q;
                end
                if (pickup || (tick_4hz && (life_q == LIFE_LAST))) begin
                    valid_d     = 1'b0;
                    disp_type_d = 3'd0;
                    disp_x_d    = 5'd0;
                    disp_y_d    = 5'd0;
                    life_d      = 8'd0;
                    state_d     = S_IDLE;
                end else if (tick_4hz) begin
                    life_d = life_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            type_q      <= 3'd0;
            tries_q     <= 4'd0;
            life_q      <= 8'd0;
            qry_x_q     <= 5'd0;
            qry_y_q     <= 5'd0;
            finish_q    <= 1'b0;
            valid_q     <= 1'b0;
            disp_type_q <= 3'd0;
            disp_x_q    <= 5'd0;
            disp_y_q    <= 5'd0;
            pulse_q     <= 1'b0;
            rtype_q     <= 3'd0;
        end else begin
            state_q     <= state_d;
            type_q      <= type_d;
            tries_q     <= tries_d;
            life_q      <= life_d;
            qry_x_q     <= qry_x_d;
            qry_y_q     <= qry_y_d;
            finish_q    <= finish_d;
            valid_q     <= valid_d;
            disp_type_q <= disp_type_d;
            disp_x_q    <= disp_x_d;
            disp_y_q    <= disp_y_d;
            pulse_q     <= pulse_d;
            rtype_q     <= rtype_d;
        end
    end

    assign set_finish     = finish_q;
    assign map_qry_x      = qry_x_q;
    assign map_qry_y      = qry_y_q;
    assign item_valid     = valid_q;
    assign item_disp_type = disp_type_q;
    assign item_disp_x    = disp_x_q;
    assign item_disp_y    = disp_y_q;
    assign reward_pulse   = pulse_q;
    assign reward_type    = rtype_q;

endmodule
